// File: rtl/vl6180x_i2c_target.sv
// rtl/vl6180x_i2c_target.sv - VL6180X register-file emulator behind an I2C target port
// Optional: GPIO1_IRQ_EN adds the active-low gpio1_n interrupt output.
module vl6180x_i2c_target #(
  parameter logic [6:0] DEV_ADDR = 7'h29,
  parameter int         ADDR_W   = 10,
  parameter int         HOLD_CYC = 3
) (
  input  logic       CLK_12M,
  input  logic       RST,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  input  logic       range_we,
  input  logic [7:0] range_val,
`ifdef GPIO1_IRQ_EN
  output logic       gpio1_n,
`endif
  output logic       busy
);

  localparam int MEM_W  = (1 << ADDR_W) * 8;
  localparam int HOLD_W = $clog2(HOLD_CYC + 1);

  localparam logic [ADDR_W-1:0] REG_INT_CLR  = ADDR_W'('h015);
  localparam logic [ADDR_W-1:0] REG_FRESH    = ADDR_W'('h016);
  localparam logic [ADDR_W-1:0] REG_INT_STAT = ADDR_W'('h04F);
  localparam logic [ADDR_W-1:0] REG_RANGE    = ADDR_W'('h062);

  localparam logic [MEM_W-1:0] MEM_RST = MEM_W'(8'hB4) | (MEM_W'(8'h01) << (8 * 'h016));

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_IDX_HI, S_IDX_LO, S_WR_DATA, S_RD_DATA, S_IGNORE
  } state_t;

  logic scl_s1_q, scl_s2_q, scl_p_q;
  logic sda_s1_q, sda_s2_q, sda_p_q;

  state_t            state_q, state_d, nxt_state;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [6:0]        shift_q, shift_d;
  logic [7:0]        idx_hi_q, idx_hi_d;
  logic [15:0]       index_q, index_d;
  logic [7:0]        tx_q, tx_d;
  logic              rw_q, rw_d;
  logic              busy_q, busy_d;
  logic              sda_oe_q, sda_oe_d;
  logic              oe_pend_q, oe_pend_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [MEM_W-1:0]  mem_q, mem_d;

  logic       scl_rise, scl_fall, start_ev, stop_ev;
  logic [7:0] rx_byte, rd_byte;

  assign scl_rise = scl_s2_q & ~scl_p_q;
  assign scl_fall = ~scl_s2_q & scl_p_q;
  assign start_ev = scl_s2_q & scl_p_q & sda_p_q & ~sda_s2_q;
  assign stop_ev  = scl_s2_q & scl_p_q & ~sda_p_q & sda_s2_q;

  assign rx_byte = {shift_q, sda_s2_q};
  assign rd_byte = mem_q[{index_q[ADDR_W-1:0], 3'b000} +: 8];

  assign sda_oe = sda_oe_q;
  assign busy   = busy_q;

`ifdef GPIO1_IRQ_EN
  assign gpio1_n = ~|mem_q[{REG_INT_STAT, 3'b000} +: 8];
`endif

  always_comb begin
    state_d   = state_q;
    nxt_state = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    idx_hi_d  = idx_hi_q;
    index_d   = index_q;
    tx_d      = tx_q;
    rw_d      = rw_q;
    busy_d    = busy_q;
    sda_oe_d  = sda_oe_q;
    oe_pend_d = oe_pend_q;
    hold_d    = hold_q;
    mem_d     = mem_q;

    // SDA may only move once the hold delay after an SCL fall has elapsed
    if (hold_q != '0) begin
      hold_d = hold_q - HOLD_W'(1);
      if (hold_q == HOLD_W'(1)) sda_oe_d = oe_pend_q;
    end

    if (stop_ev) begin
      state_d   = S_IDLE;
      busy_d    = 1'b0;
      sda_oe_d  = 1'b0;
      hold_d    = '0;
      bit_cnt_d = 4'd0;
    end else if (start_ev) begin
      state_d   = S_ADDR;
      busy_d    = 1'b1;
      sda_oe_d  = 1'b0;
      hold_d    = '0;
      bit_cnt_d = 4'd0;
    end else if (state_q != S_IDLE && state_q != S_IGNORE) begin
      if (scl_rise) begin
        if (bit_cnt_q < 4'd8) begin
          shift_d   = rx_byte[6:0];
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            case (state_q)
              S_ADDR: begin
                if (rx_byte[7:1] == DEV_ADDR) begin
                  rw_d = rx_byte[0];
                end else begin
                  state_d = S_IGNORE;
                  busy_d  = 1'b0;
                end
              end
              S_IDX_HI: idx_hi_d = rx_byte;
              S_IDX_LO: index_d  = {idx_hi_q, rx_byte};
              S_WR_DATA: begin
                mem_d[{index_q[ADDR_W-1:0], 3'b000} +: 8] = rx_byte;
                if (index_q[ADDR_W-1:0] == REG_INT_CLR && rx_byte[0])
                  mem_d[{REG_INT_STAT, 3'b000} +: 8] = 8'h00;
                index_d = index_q + 16'd1;
              end
              default: ;
            endcase
          end
        end else if (bit_cnt_q == 4'd8) begin
          bit_cnt_d = 4'd9;
          if (state_q == S_RD_DATA) begin
            if (sda_s2_q) begin
              state_d = S_IGNORE;
              busy_d  = 1'b0;
            end else begin
              index_d = index_q + 16'd1;
            end
          end
        end
      end else if (scl_fall) begin
        hold_d    = HOLD_W'(HOLD_CYC);
        oe_pend_d = 1'b0;
        if (bit_cnt_q == 4'd8) begin
          oe_pend_d = (state_q != S_RD_DATA);
        end else if (bit_cnt_q == 4'd9) begin
          bit_cnt_d = 4'd0;
          case (state_q)
            S_ADDR:   nxt_state = rw_q ? S_RD_DATA : S_IDX_HI;
            S_IDX_HI: nxt_state = S_IDX_LO;
            S_IDX_LO: nxt_state = S_WR_DATA;
            default:  nxt_state = state_q;
          endcase
          state_d = nxt_state;
          if (nxt_state == S_RD_DATA) begin
            tx_d      = rd_byte;
            oe_pend_d = ~rd_byte[7];
          end
        end else if (state_q == S_RD_DATA) begin
          oe_pend_d = ~tx_q[3'd7 - bit_cnt_q[2:0]];
        end
      end
    end

    // Host sample injection overrides any same-cycle I2C write
    if (range_we) begin
      mem_d[{REG_RANGE, 3'b000} +: 8]    = range_val;
      mem_d[{REG_INT_STAT, 3'b000} +: 8] = 8'h04;
      mem_d[{REG_FRESH, 3'b000} +: 8]    = 8'h00;
    end
  end

  always_ff @(posedge CLK_12M or posedge RST) begin
    if (RST) begin
      scl_s1_q  <= 1'b1;
      scl_s2_q  <= 1'b1;
      scl_p_q   <= 1'b1;
      sda_s1_q  <= 1'b1;
      sda_s2_q  <= 1'b1;
      sda_p_q   <= 1'b1;
      state_q   <= S_IDLE;
      bit_cnt_q <= 4'd0;
      shift_q   <= 7'd0;
      idx_hi_q  <= 8'd0;
      index_q   <= 16'd0;
      tx_q      <= 8'd0;
      rw_q      <= 1'b0;
      busy_q    <= 1'b0;
      sda_oe_q  <= 1'b0;
      oe_pend_q <= 1'b0;
      hold_q    <= '0;
      mem_q     <= MEM_RST;
    end else begin
      scl_s1_q  <= scl_i;
      scl_s2_q  <= scl_s1_q;
      scl_p_q   <= scl_s2_q;
      sda_s1_q  <= sda_i;
      sda_s2_q  <= sda_s1_q;
      sda_p_q   <= sda_s2_q;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      idx_hi_q  <= idx_hi_d;
      index_q   <= index_d;
      tx_q      <= tx_d;
      rw_q      <= rw_d;
      busy_q    <= busy_d;
      sda_oe_q  <= sda_oe_d;
      oe_pend_q <= oe_pend_d;
      hold_q    <= hold_d;
      mem_q     <= mem_d;
    end
  end

endmodule
